// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM encoding
// and source-count constants.
package intr_ctrl_pkg;

  localparam int          NUM_SRC   = 6;
  localparam logic [2:0]  NONE_ID   = 3'd7;
  localparam logic [31:0] BASE_ADDR = 32'h0000_7F40;

  localparam logic [1:0] OFF_CTRL = 2'd0;
  localparam logic [1:0] OFF_MASK = 2'd1;
  localparam logic [1:0] OFF_PEND = 2'd2;
  localparam logic [1:0] OFF_EOI  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // NONE_ID (or any out-of-range index) maps to an all-zero vector
  function automatic logic [NUM_SRC-1:0] onehot(input logic [2:0] id);
    onehot = (id < 3'(NUM_SRC)) ? (NUM_SRC'(1) << id) : '0;
  endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-wins priority encoder over the interrupt sources, with a valid
// flag; reports NONE_ID when no request is present.
module intr_prio_enc
  import intr_ctrl_pkg::*;
(
  input  logic [NUM_SRC-1:0] i_req,
  output logic [2:0]         o_id,
  output logic               o_vld
);

  always_comb begin
    o_id  = NONE_ID;
    o_vld = 1'b0;
    // scan downward so the lowest set index is the last assignment
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_id  = 3'(i);
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Six-source interrupt controller: per-source edge/level pending, mask and
// global enable, fixed priority, and a REQ/SERVICE handshake with CP0.
module intr_ctrl
  import intr_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [31:0]        addr,
  input  logic               we,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic               cpu_ack,
  output logic [NUM_SRC-1:0] hwint,
  output logic [2:0]         irq_id
);

  logic               r_gen;
  logic [NUM_SRC-1:0] r_edge_mode;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_pend_edge;
  logic [NUM_SRC-1:0] r_src_q;
  logic [NUM_SRC-1:0] r_hwint;
  logic [2:0]         r_req_id;
  logic [2:0]         r_act_id;
  logic               r_insvc;
  state_t             r_state;

  logic               w_sel;
  logic               w_wr;
  logic               w_wr_ctrl;
  logic               w_wr_mask;
  logic               w_wr_pend;
  logic               w_eoi;
  logic               w_ack;
  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] w_pend;
  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_pend_set;
  logic [NUM_SRC-1:0] w_pend_clr;
  logic [2:0]         w_id;
  logic               w_vld;
  logic               w_unused_bits;

  assign w_sel     = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr      = we & w_sel;
  assign w_wr_ctrl = w_wr & (addr[3:2] == OFF_CTRL);
  assign w_wr_mask = w_wr & (addr[3:2] == OFF_MASK);
  assign w_wr_pend = w_wr & (addr[3:2] == OFF_PEND);
  assign w_eoi     = w_wr & (addr[3:2] == OFF_EOI);
  assign w_ack     = (r_state == ST_REQ) & cpu_ack;

  assign w_edge = src_irq & ~r_src_q;
  // level-mode sources bypass the pending register entirely
  assign w_pend = (r_edge_mode & r_pend_edge) | (~r_edge_mode & src_irq);
  assign w_elig = w_pend & r_mask & {NUM_SRC{r_gen}};

  assign w_pend_set = w_edge & r_edge_mode;
  assign w_pend_clr = ((w_wr_pend ? wdata[NUM_SRC-1:0] : '0) |
                       (w_ack ? onehot(r_req_id) : '0)) & r_edge_mode;

  assign w_unused_bits = ^{wdata[31:14], wdata[7:6], addr[1:0]};

  intr_prio_enc u_prio (
    .i_req (w_elig),
    .o_id  (w_id),
    .o_vld (w_vld)
  );

  assign irq_id = w_id;
  assign hwint  = r_hwint;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gen       <= 1'b0;
      r_edge_mode <= '0;
      r_mask      <= '0;
      r_pend_edge <= '0;
      r_src_q     <= '0;
    end else begin
      r_src_q <= src_irq;
      if (w_wr_ctrl) begin
        r_gen       <= wdata[0];
        r_edge_mode <= wdata[13:8];
      end
      if (w_wr_mask)
        r_mask <= wdata[NUM_SRC-1:0];
      // a fresh edge beats a same-cycle clear
      r_pend_edge <= (r_pend_edge & ~w_pend_clr) | w_pend_set;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_hwint  <= '0;
      r_req_id <= NONE_ID;
      r_act_id <= 3'd0;
      r_insvc  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_vld) begin
            r_state  <= ST_REQ;
            r_req_id <= w_id;
            r_hwint  <= onehot(w_id);
          end
        end
        ST_REQ: begin
          // the CPU has already committed once it acks, so ack outranks a drop
          if (cpu_ack) begin
            r_state  <= ST_SERVICE;
            r_act_id <= r_req_id;
            r_insvc  <= 1'b1;
            r_hwint  <= '0;
          end else if (!w_elig[r_req_id]) begin
            r_state <= ST_IDLE;
            r_hwint <= '0;
          end else if (w_id != r_req_id) begin
            r_req_id <= w_id;
            r_hwint  <= onehot(w_id);
          end
        end
        ST_SERVICE: begin
          if (w_eoi) begin
            r_state <= ST_IDLE;
            r_insvc <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_hwint <= '0;
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (w_sel) begin
      case (addr[3:2])
        OFF_CTRL: rdata = {18'b0, r_edge_mode, 7'b0, r_gen};
        OFF_MASK: rdata = {26'b0, r_mask};
        OFF_PEND: rdata = {26'b0, w_pend};
        OFF_EOI:  rdata = {r_insvc, 28'b0, r_act_id};
        default:  rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios followed by random traffic, all
// checked against a behavioural model of the controller.
module tb_intr_ctrl;

  localparam logic [31:0] A_CTRL = 32'h0000_7F40;
  localparam logic [31:0] A_MASK = 32'h0000_7F44;
  localparam logic [31:0] A_PEND = 32'h0000_7F48;
  localparam logic [31:0] A_EOI  = 32'h0000_7F4C;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  src_irq;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        cpu_ack;
  logic [5:0]  hwint;
  logic [2:0]  irq_id;

  int checks   = 0;
  int failures = 0;

  intr_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .src_irq (src_irq),
    .addr    (addr),
    .we      (we),
    .wdata   (wdata),
    .rdata   (rdata),
    .cpu_ack (cpu_ack),
    .hwint   (hwint),
    .irq_id  (irq_id)
  );

  always #5 clk = ~clk;

  // behavioural model state
  bit       m_gen;
  bit [5:0] m_edge, m_mask, m_epend, m_prev, m_hw;
  bit       m_req, m_svc;
  int       m_req_id, m_act_id;

  function automatic bit m_pend(int i);
    return m_edge[i] ? m_epend[i] : bit'(src_irq[i]);
  endfunction

  function automatic bit m_elig(int i);
    return m_pend(i) && m_mask[i] && m_gen;
  endfunction

  function automatic int m_best();
    for (int i = 0; i < 6; i++)
      if (m_elig(i)) return i;
    return 7;
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a);
    int v;
    if (a[31:4] != 28'h7F4) return 32'd0;
    v = 0;
    case (int'(a[3:2]))
      0: v = int'(m_gen) + int'(m_edge) * 256;
      1: v = int'(m_mask);
      2: for (int i = 0; i < 6; i++) if (m_pend(i)) v += (1 << i);
      default: v = (m_svc ? 32'h8000_0000 : 0) + m_act_id;
    endcase
    return 32'(v);
  endfunction

  task automatic m_reset();
    m_gen = 0; m_edge = 0; m_mask = 0; m_epend = 0; m_prev = 0; m_hw = 0;
    m_req = 0; m_svc = 0; m_req_id = 0; m_act_id = 0;
  endtask

  task automatic m_step();
    bit       wr;
    int       r, best;
    bit [5:0] nep;
    if (reset) begin
      m_reset();
      return;
    end
    wr   = we && (addr[31:4] == 28'h7F4);
    r    = int'(addr[3:2]);
    best = m_best();
    nep  = m_epend;
    for (int i = 0; i < 6; i++) begin
      if (m_edge[i]) begin
        if ((wr && r == 2 && wdata[i]) || (m_req && cpu_ack && m_req_id == i)) nep[i] = 0;
        if (src_irq[i] && !m_prev[i]) nep[i] = 1;
      end
    end
    if (m_svc) begin
      if (wr && r == 3) m_svc = 0;
    end else if (m_req) begin
      if (cpu_ack) begin
        m_req = 0; m_svc = 1; m_act_id = m_req_id; m_hw = 0;
      end else if (!m_elig(m_req_id)) begin
        m_req = 0; m_hw = 0;
      end else if (best < m_req_id) begin
        m_req_id = best; m_hw = 6'(1) << best;
      end
    end else if (best != 7) begin
      m_req = 1; m_req_id = best; m_hw = 6'(1) << best;
    end
    m_epend = nep;
    m_prev  = src_irq;
    if (wr && r == 0) begin m_gen = wdata[0]; m_edge = wdata[13:8]; end
    if (wr && r == 1) m_mask = wdata[5:0];
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // compare outputs against the model, then advance one clock
  task automatic cyc(string tag);
    #1;
    chk({tag, ".hwint"},  32'(hwint),  32'(m_hw));
    chk({tag, ".irq_id"}, 32'(irq_id), 32'(m_best()));
    chk({tag, ".rdata"},  rdata,       m_read(addr));
    m_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d, string tag);
    addr = a; we = 1'b1; wdata = d;
    cyc(tag);
    we = 1'b0; wdata = '0;
  endtask

  task automatic expect_rd(logic [31:0] a, logic [31:0] exp, string tag);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; src_irq = '0; addr = '0; we = 1'b0; wdata = '0; cpu_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_reset();
    cyc("rst");
    reset = 1'b0;
    chk("rst.hwint", 32'(hwint), 32'h0);
    chk("rst.irq_id", 32'(irq_id), 32'd7);
    expect_rd(A_CTRL, 32'h0, "rst.ctrl");

    // single edge source through the full handshake
    wr(A_CTRL, 32'h0000_3F01, "t1.ctrl");
    wr(A_MASK, 32'h3F, "t1.mask");
    src_irq = 6'h02; cyc("t1.rise"); src_irq = '0;
    expect_rd(A_PEND, 32'h02, "t1.pend");
    chk("t1.hw_early", 32'(hwint), 32'h0);
    cyc("t1.wait");
    chk("t1.hwint", 32'(hwint), 32'h02);
    cpu_ack = 1'b1; cyc("t1.ack"); cpu_ack = 1'b0;
    chk("t1.hw_ack", 32'(hwint), 32'h0);
    expect_rd(A_EOI, 32'h8000_0001, "t1.act");
    expect_rd(A_PEND, 32'h0, "t1.pend_clr");
    wr(A_EOI, 32'h0, "t1.eoi");
    repeat (2) cyc("t1.idle");

    // simultaneous edges resolve by priority, loser served after EOI
    src_irq = 6'h0A; cyc("t2.rise"); src_irq = '0;
    #1 chk("t2.irq_id", 32'(irq_id), 32'd1);
    cyc("t2.wait");
    chk("t2.hw1", 32'(hwint), 32'h02);
    cpu_ack = 1'b1; cyc("t2.ack"); cpu_ack = 1'b0;
    wr(A_EOI, 32'h0, "t2.eoi");
    cyc("t2.rearb");
    chk("t2.hw3", 32'(hwint), 32'h08);
    cpu_ack = 1'b1; cyc("t2.ack3"); cpu_ack = 1'b0;
    wr(A_EOI, 32'h0, "t2.eoi3");
    cyc("t2.idle");

    // level source masked off while requesting
    wr(A_CTRL, 32'h0000_0001, "t3.ctrl");
    src_irq = 6'h01; cyc("t3.req");
    chk("t3.hw_req", 32'(hwint), 32'h01);
    wr(A_MASK, 32'h3E, "t3.mask");
    cyc("t3.drop");
    chk("t3.hw_drop", 32'(hwint), 32'h0);
    cyc("t3.idle");
    chk("t3.hw_idle", 32'(hwint), 32'h0);
    src_irq = '0;

    // edge set coinciding with W1C of the same bit
    wr(A_CTRL, 32'h0000_3F01, "t4.ctrl");
    wr(A_MASK, 32'h0, "t4.mask");
    src_irq = 6'h04; cyc("t4.rise1"); src_irq = '0;
    cyc("t4.low");
    src_irq = 6'h04; wr(A_PEND, 32'h04, "t4.w1c_set"); src_irq = '0;
    expect_rd(A_PEND, 32'h04, "t4.setwins");
    wr(A_PEND, 32'h04, "t4.w1c");
    expect_rd(A_PEND, 32'h0, "t4.cleared");

    // ack in IDLE and EOI in REQ are ignored
    cpu_ack = 1'b1; cyc("t5.ack_idle"); cpu_ack = 1'b0;
    chk("t5.hw_idle", 32'(hwint), 32'h0);
    wr(A_MASK, 32'h3F, "t5.mask");
    src_irq = 6'h10; cyc("t5.rise"); src_irq = '0;
    cyc("t5.wait");
    wr(A_EOI, 32'h0, "t5.eoi_req");
    chk("t5.hw_hold", 32'(hwint), 32'h10);
    cpu_ack = 1'b1; cyc("t5.ack"); cpu_ack = 1'b0;
    expect_rd(A_EOI, 32'h8000_0004, "t5.act");
    wr(A_EOI, 32'h0, "t5.eoi");

    // reset during SERVICE with sources pending
    src_irq = 6'h01; cyc("t6.rise"); src_irq = '0;
    cyc("t6.wait");
    cpu_ack = 1'b1; cyc("t6.ack"); cpu_ack = 1'b0;
    src_irq = 6'h21; cyc("t6.rise2"); src_irq = '0;
    expect_rd(A_PEND, 32'h21, "t6.pend");
    expect_rd(A_EOI, 32'h8000_0000, "t6.act");
    reset = 1'b1; cyc("t6.rst"); reset = 1'b0;
    expect_rd(A_CTRL, 32'h0, "t6.ctrl0");
    expect_rd(A_MASK, 32'h0, "t6.mask0");
    expect_rd(A_PEND, 32'h0, "t6.pend0");
    expect_rd(A_EOI, 32'h0, "t6.act0");
    chk("t6.hw0", 32'(hwint), 32'h0);
    chk("t6.id7", 32'(irq_id), 32'd7);
    repeat (3) cyc("t6.after");
    chk("t6.hw_after", 32'(hwint), 32'h0);

    // random traffic
    for (int n = 0; n < 800; n++) begin
      reset   = ($urandom_range(0, 99) == 0);
      src_irq = src_irq ^ 6'($urandom & $urandom & $urandom);
      we      = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0: addr = A_CTRL;
        1: addr = A_MASK;
        2: addr = A_PEND;
        3: addr = A_EOI;
        4: addr = 32'h0000_7F50;
        default: addr = 32'h1000_7F44;
      endcase
      wdata   = $urandom;
      cpu_ack = ($urandom_range(0, 2) == 0);
      cyc("rnd");
    end
    reset = 1'b0; we = 1'b0; cpu_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
